// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - write/read-back BIST sequencer for a synchronous RAM
// Optional RAM_BIST_INV_EN adds a second pass using the inverted pattern.
module ram_bist_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 1024,
    parameter int PAT_SEED = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ADDR_W:0]   fail_cnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_cs,
    output logic              mem_wr,
    output logic              mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp_data;
    logic [ADDR_W-1:0] exp_addr;
    logic              cmp_valid;
    logic              mismatch;
    logic              last_addr;
    logic              run_start;
    logic              run_end;
    logic [DATA_W-1:0] pat_cur;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        return DATA_W'((32'(a) << 1) + 32'(PAT_SEED));
    endfunction

`ifdef RAM_BIST_INV_EN
    logic inv_sel;
    assign pat_cur = pattern(addr) ^ {DATA_W{inv_sel}};
`else
    assign pat_cur = pattern(addr);
`endif

    assign last_addr = (addr == LAST_ADDR);
    assign run_start = (state == S_IDLE) && start;
    assign run_end   = (state == S_DRAIN) && (state_nxt == S_DONE);
    assign mismatch  = cmp_valid && (mem_rdata != exp_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_cs    = 1'b0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                busy      = 1'b1;
                mem_cs    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = addr;
                mem_wdata = pat_cur;
                if (last_addr) state_nxt = S_READ;
            end
            S_READ: begin
                busy     = 1'b1;
                mem_cs   = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = addr;
                if (last_addr) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
`ifdef RAM_BIST_INV_EN
                state_nxt = inv_sel ? S_DONE : S_WRITE;
`else
                state_nxt = S_DONE;
`endif
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read data returns one cycle after the request, so the expectation trails by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            exp_data  <= '0;
            exp_addr  <= '0;
            cmp_valid <= 1'b0;
        end else begin
            if ((state == S_WRITE) || (state == S_READ)) begin
                addr <= last_addr ? '0 : addr + ADDR_W'(1);
            end else begin
                addr <= '0;
            end
            exp_data  <= pat_cur;
            exp_addr  <= addr;
            cmp_valid <= (state == S_READ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt  <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
        end else if (run_start) begin
            fail_cnt  <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
        end else begin
            if (mismatch && (fail_cnt != '1)) begin
                fail_cnt <= fail_cnt + (ADDR_W + 1)'(1);
            end
            if (mismatch && (fail_cnt == '0)) begin
                fail_addr <= exp_addr;
            end
            if (run_end) begin
                pass <= (fail_cnt == '0) && !mismatch;
            end
        end
    end

`ifdef RAM_BIST_INV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_sel <= 1'b0;
        end else if (run_start) begin
            inv_sel <= 1'b0;
        end else if ((state == S_DRAIN) && !inv_sel) begin
            inv_sel <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb/tb_ram_bist_ctrl.sv - self-checking bench for ram_bist_ctrl with a faulty-RAM model
module tb_ram_bist_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1024;
    localparam int SEED   = 0;
`ifdef RAM_BIST_INV_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int DONE_CYC = (PASSES == 2) ? 4 * DEPTH + 3 : 2 * DEPTH + 2;
    localparam int CNT_MAX  = (1 << (ADDR_W + 1)) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy, done, pass;
    logic [ADDR_W-1:0] fail_addr;
    logic [ADDR_W:0]   fail_cnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_cs, mem_wr, mem_rd;

    ram_bist_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PAT_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .pass(pass), .fail_addr(fail_addr), .fail_cnt(fail_cnt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem   [DEPTH];
    logic [DATA_W-1:0] fmask [DEPTH];
    logic              l_cs = 0, l_wr = 0, l_rd = 0;
    logic [ADDR_W-1:0] l_addr = '0;
    logic [DATA_W-1:0] l_wdata = '0;

    int seq_err = 0;
    int bus_err = 0;
    int wr_idx = 0;
    int rd_idx = 0;
    logic [DATA_W-1:0] w5_p0 = '0, w200_p0 = '0, w5_p1 = '0;

    function automatic logic [DATA_W-1:0] pat(input int a, input int p);
        logic [DATA_W-1:0] v;
        v = DATA_W'(2 * a + SEED);
        if (p != 0) v = ~v;
        return v;
    endfunction

    // Reference: per pass, every address is read as P|stuck-ones and compared with P.
    function automatic void model(output logic ep, output int ec, output int efa);
        ec  = 0;
        efa = 0;
        for (int p = 0; p < PASSES; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                logic [DATA_W-1:0] w;
                w = pat(a, p);
                if ((w | fmask[a]) != w) begin
                    if (ec == 0) efa = a;
                    if (ec < CNT_MAX) ec++;
                end
            end
        end
        ep = (ec == 0);
    endfunction

    always @(negedge clk) begin
        if (mem_wr && mem_rd) bus_err++;
        if (mem_cs != (mem_wr || mem_rd)) bus_err++;
        if (!mem_wr && mem_wdata != '0) bus_err++;
        if (mem_wr) begin
            if (int'(mem_addr) != wr_idx % DEPTH) seq_err++;
            if (mem_wdata != pat(wr_idx % DEPTH, wr_idx / DEPTH)) seq_err++;
            if (rd_idx != (wr_idx / DEPTH) * DEPTH) seq_err++;
            if (wr_idx == 5) w5_p0 = mem_wdata;
            if (wr_idx == 200) w200_p0 = mem_wdata;
            if (wr_idx == DEPTH + 5) w5_p1 = mem_wdata;
            wr_idx++;
        end
        if (mem_rd) begin
            if (int'(mem_addr) != rd_idx % DEPTH) seq_err++;
            if (wr_idx != (rd_idx / DEPTH + 1) * DEPTH) seq_err++;
            rd_idx++;
        end
        if (!busy) begin
            wr_idx = 0;
            rd_idx = 0;
        end
        l_cs    = mem_cs;
        l_wr    = mem_wr;
        l_rd    = mem_rd;
        l_addr  = mem_addr;
        l_wdata = mem_wdata;
    end

    always @(posedge clk) begin
        if (l_cs && l_wr) mem[l_addr] <= l_wdata;
        if (l_cs && l_rd) mem_rdata <= mem[l_addr] | fmask[l_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) fmask[a] = '0;
    endtask

    task automatic run_check(input string nm, input int extra, input logic ep,
                             input int ec, input int efa);
        int n, done_at, ndone, se0, be0;
        logic p_at, p_held;
        int c_at, fa_at;
        se0 = seq_err;
        be0 = bus_err;
        done_at = -1;
        ndone = 0;
        p_at = 0; p_held = 0; c_at = -1; fa_at = -1;
        @(posedge clk); #1;
        start = 1'b1;
        n = 0;
        while (n < DONE_CYC + 20) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = n;
                    p_at  = pass;
                    c_at  = int'(fail_cnt);
                    fa_at = int'(fail_addr);
                end
            end
            @(posedge clk); #1;
            start = (extra >= 0) && (n + 1 == extra);
            n++;
            if (done_at >= 0 && n >= done_at + 3) break;
        end
        start = 1'b0;
        p_held = pass;
        chk({nm, ".done_at"}, done_at, DONE_CYC);
        chk({nm, ".ndone"}, ndone, 1);
        chk({nm, ".pass"}, int'(p_at), int'(ep));
        chk({nm, ".fail_cnt"}, c_at, ec);
        chk({nm, ".fail_addr"}, fa_at, efa);
        chk({nm, ".pass_held"}, int'(p_held), int'(ep));
        chk({nm, ".seq_err"}, seq_err - se0, 0);
        chk({nm, ".bus_err"}, bus_err - be0, 0);
    endtask

    typedef struct {
        string            nm;
        int               fa0; logic [DATA_W-1:0] fm0;
        int               fa1; logic [DATA_W-1:0] fm1;
        int               fa2; logic [DATA_W-1:0] fm2;
        logic             ep;
        int               ec;
        int               efa;
    } vec_t;

    vec_t vt [4];

    initial begin
        int cs_hi, ndone;
        logic mp;
        int mc, mfa, nf, fa;

        vt[0] = '{"clean",  -1, 8'h00, -1, 8'h00, -1, 8'h00, 1'b1, 0, 0};
`ifdef RAM_BIST_INV_EN
        vt[1] = '{"stuck",   7, 8'h08, 300, 8'h01, 301, 8'h01, 1'b0, 3, 300};
`else
        vt[1] = '{"stuck",   7, 8'h08, 300, 8'h01, 301, 8'h01, 1'b0, 2, 300};
`endif
        vt[2] = '{"edges",   0, 8'h80, DEPTH - 1, 8'h01, -1, 8'h00, 1'b0, 2, 0};
        vt[3] = '{"last",   DEPTH - 1, 8'h01, -1, 8'h00, -1, 8'h00, 1'b0, 1, DEPTH - 1};

        clear_faults();
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;

        // Reset then idle
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.status", int'({busy, done, pass, fail_addr, fail_cnt}), 0);
        chk("rst.mem", int'({mem_addr, mem_wdata, mem_cs, mem_wr, mem_rd}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cs_hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_cs || busy || done) cs_hi++;
        end
        chk("idle.quiet", cs_hi, 0);

        // Table-driven fault scenarios
        for (int i = 0; i < 4; i++) begin
            clear_faults();
            if (vt[i].fa0 >= 0) fmask[vt[i].fa0] = vt[i].fm0;
            if (vt[i].fa1 >= 0) fmask[vt[i].fa1] = vt[i].fm1;
            if (vt[i].fa2 >= 0) fmask[vt[i].fa2] = vt[i].fm2;
            run_check(vt[i].nm, -1, vt[i].ep, vt[i].ec, vt[i].efa);
            if (i == 0) begin
                chk("clean.w5", int'(w5_p0), 10);
                chk("clean.w200", int'(w200_p0), 144);
`ifdef RAM_BIST_INV_EN
                chk("clean.w5_inv", int'(w5_p1), 245);
`endif
            end
        end

        // Start pulse while busy is ignored
        clear_faults();
        run_check("restart", 500, 1'b1, 0, 0);

        // Reset in the middle of the READ phase
        fmask[42] = 8'h01;
        @(posedge clk); #1;
        start = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            if (i == 0) start = 1'b0;
        end
        chk("midrst.pre_rd", int'(mem_rd), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst.status", int'({busy, done, pass, fail_addr, fail_cnt}), 0);
        chk("midrst.mem", int'({mem_addr, mem_wdata, mem_cs, mem_wr, mem_rd}), 0);
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst.nodone", ndone, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_faults();
        run_check("fresh", -1, 1'b1, 0, 0);

        // Randomised stuck-at-one faults against the reference model
        for (int r = 0; r < 3; r++) begin
            clear_faults();
            nf = int'($urandom_range(1, 8));
            for (int k = 0; k < nf; k++) begin
                fa = int'($urandom_range(0, DEPTH - 1));
                fmask[fa] = fmask[fa] | DATA_W'($urandom);
            end
            model(mp, mc, mfa);
            run_check($sformatf("rand%0d", r), -1, mp, mc, mfa);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Sequencer that drives the 1024x8 synchronous RAM's addr/data/cs/wr/rd pins and checks the data it reads back.
- Sits directly upstream of the RAM and consumes its read data.
- On start: writes a deterministic pattern to every location, reads every location back, compares each word, and reports pass/fail, first failing address and error count.
- Replaces the free-running random-address stimulus with a bounded, self-checking sequence.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 1024, number of locations tested (addresses 0..DEPTH-1; DEPTH <= 2^ADDR_W).
- PAT_SEED, 0, additive seed in the pattern function.

Ports:
- clk  input  1  rising-edge clock, shared with the RAM.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a test run; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until DONE exits.
- done  output  1  one-cycle pulse when the run completes.
- pass  output  1  result of the last completed run; valid when done=1, held until the next start.
- fail_addr  output  ADDR_W  first mismatching address of the last run; 0 if none.
- fail_cnt  output  ADDR_W+1  mismatch count, saturating at all-ones.
- mem_addr  output  ADDR_W  RAM address.
- mem_wdata  output  DATA_W  RAM write data.
- mem_rdata  input  DATA_W  RAM read data, registered by the RAM one clock after a read request.
- mem_cs  output  1  RAM chip select.
- mem_wr  output  1  RAM write enable.
- mem_rd  output  1  RAM read enable.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0.
- Pattern: P(a) = (2*a + PAT_SEED) mod 2^DATA_W.
- States: IDLE, WRITE, READ, DRAIN, DONE. Addresses ascend 0..DEPTH-1 in WRITE and in READ.
- IDLE:
  - Memory outputs are all 0.
  - start=1 moves to WRITE, clears fail_cnt, fail_addr and pass, and sets busy.
- WRITE: one word per cycle.
  - mem_cs=1, mem_wr=1, mem_rd=0, mem_addr=a, mem_wdata=P(a).
  - After a=DEPTH-1, go to READ with a=0.
- READ: one request per cycle.
  - mem_cs=1, mem_rd=1, mem_wr=0, mem_addr=a.
  - The expected value and address are pipelined one cycle.
  - mem_rdata is compared in the following cycle.
  - After a=DEPTH-1, go to DRAIN.
- DRAIN:
  - Memory outputs are 0.
  - Performs the final comparison.
  - Next state is DONE.
- Compare (READ cycles after the first, and DRAIN): on mismatch, fail_cnt increments with saturation; fail_addr captures the address only when fail_cnt was 0.
- DONE:
  - done=1 for one cycle; pass=(fail_cnt==0); busy=0.
  - Next state is IDLE.
- Latency: with start sampled in cycle 0:
  - WRITE occupies cycles 1..DEPTH.
  - READ occupies cycles DEPTH+1..2*DEPTH.
  - DRAIN is cycle 2*DEPTH+1.
  - done is high in cycle 2*DEPTH+2.
- mem_wr and mem_rd are never both 1. mem_cs=0 whenever neither is asserted.
- start outside IDLE is ignored; start held high re-triggers only after returning to IDLE.
- Reset mid-run: aborts immediately to the reset values; the partial result is discarded.
- mem_wdata is driven only during WRITE and is 0 otherwise. The RAM's shared bus direction is handled at the top level using mem_rd.

Optional Feature:
- Macro RAM_BIST_INV_EN.
- When defined:
  - After the first DRAIN, a second WRITE/READ/DRAIN pass runs with pattern ~P(a).
  - Errors accumulate across both passes, and fail_addr records the first failure overall.
  - done occurs in cycle 4*DEPTH+3.
  - An internal pass-select bit exists only under the macro.
- When undefined: single pass only, with the timing stated above.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, then 1 with start=0 -> all outputs 0; mem_cs stays 0 for 20 cycles.
- Clean run, DEPTH=1024, PAT_SEED=0, ideal RAM model, start pulsed in cycle 0:
  - Writes address 5 with data 10 and address 200 with data 144.
  - done in cycle 2050; pass=1; fail_cnt=0; fail_addr=0.
- Stuck bit: RAM model forces bit 3 of address 7 to 1 on read (P(7)=14 reads back as 14) and bit 0 of addresses 300 and 301 to 1 -> pass=0, fail_cnt=2, fail_addr=300.
- Start ignored while busy: a second start pulse in cycle 500 -> a single done, still in cycle 2050; the address sequence is unperturbed.
- Reset mid-run: rst_n low in cycle 1500 (READ phase) -> outputs 0 in the same cycle, with no done. A start after release gives a full, fresh run with done 2050 cycles later.
- RAM_BIST_INV_EN defined, ideal RAM -> a write of 245 (~10) to address 5 in the second pass; done in cycle 4099; pass=1.
